wb_bus_arbiter_2m: RTL

//   Shares one Wishbone B3 classic slave port between two CPU-side bus masters:
//   m0 = data-side and m1 = instruction-side bus interface.

---
 rtl/wb_bus_arbiter_2m.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/wb_bus_arbiter_2m.sv
// Two-master Wishbone B3 classic arbiter.
// m0 is the data-side master and m1 is the instruction-side master; they share
// one slave port. Grants are registered and held for a whole cyc burst. A
// watchdog ends hung slave cycles with an error pulse to the granted master.
//
// state | meaning
// IDLE  | no grant, every output 0, arbitrate on the next edge
// GNT0  | m0 owns the slave port until m0_cyc_i drops or a timeout fires
// GNT1  | m1 owns the slave port until m1_cyc_i drops or a timeout fires
module wb_bus_arbiter_2m #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int RR_EN   = 1,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    output logic [1:0]      gnt_o
);

    localparam logic [7:0] WCNT_TC = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_last_gnt;     // 0 = m0 was granted last, 1 = m1
    logic [7:0] r_wcnt;
    logic       w_stb;
    logic       w_busy;
    logic       w_timeout;

    // Strobe of whichever master holds the grant; 0 when idle.
    assign w_stb = (r_state == ST_GNT0) ? m0_stb_i :
                   (r_state == ST_GNT1) ? m1_stb_i : 1'b0;

    // Slave is being waited on this cycle; a same-cycle ack/err beats the timeout.
    assign w_busy    = w_stb & ~s_ack_i & ~s_err_i;
    assign w_timeout = (r_wcnt == WCNT_TC) & w_busy;

    assign gnt_o = {r_state == ST_GNT1, r_state == ST_GNT0};

    // Next-state: arbitrate in IDLE, release on cyc drop or watchdog expiry.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    if (RR_EN != 0 && r_last_gnt == 1'b0)
                        w_state_nxt = ST_GNT1;
                    else
                        w_state_nxt = ST_GNT0;
                end else if (m0_cyc_i) begin
                    w_state_nxt = ST_GNT0;
                end else if (m1_cyc_i) begin
                    w_state_nxt = ST_GNT1;
                end
            end
            ST_GNT0: if (!m0_cyc_i || w_timeout) w_state_nxt = ST_IDLE;
            ST_GNT1: if (!m1_cyc_i || w_timeout) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Bus steering: granted master passes straight through, everyone else sees 0.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_dat_o = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        case (r_state)
            ST_GNT0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = w_stb;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_dat_o = s_dat_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i | w_timeout;
            end
            ST_GNT1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = w_stb;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_dat_o = s_dat_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i | w_timeout;
            end
            default: ;
        endcase
    end

    // State, last-grant memory and watchdog counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_last_gnt <= 1'b1;
            r_wcnt     <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_GNT0 && w_state_nxt == ST_IDLE)
                r_last_gnt <= 1'b0;
            else if (r_state == ST_GNT1 && w_state_nxt == ST_IDLE)
                r_last_gnt <= 1'b1;
            if (w_busy && !w_timeout)
                r_wcnt <= r_wcnt + 8'd1;
            else
                r_wcnt <= 8'd0;
        end
    end

endmodule
